// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage and dmem_ctrl.
// Both directions use valid/ready; the core side is the master.
interface dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [2:0]      req_type;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_we;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory for the MEM stage: byte-lane stores, registered one-cycle loads,
// one-entry response register, and error responses without side effects.
module dmem_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    logic [NB-1:0][7:0] mem [DEPTH];

    logic [AW-1:0]   idx;
    logic [OB-1:0]   off;
    logic [1:0]      sz;
    logic            uns;
    logic            misaligned;
    logic            out_of_range;
    logic            illegal;
    logic            req_err;
    logic            accept;
    logic            wr_en;
    logic            rd_en;
    logic [NB-1:0]   be_size;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_sh;

    logic            rsp_valid_q;
    logic            rsp_we_q;
    logic            rsp_err_q;
    logic [1:0]      sz_q;
    logic [OB-1:0]   off_q;
    logic            uns_q;
    logic [XLEN-1:0] rd_word;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sbit;
    logic [XLEN-1:0] load_val;

    assign idx = bus.req_addr[OB +: AW];
    assign off = bus.req_addr[OB-1:0];
    assign sz  = bus.req_type[1:0];
    assign uns = bus.req_type[2];

    always_comb begin
        misaligned = 1'b0;
        case (sz)
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            2'd3:    misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = |(bus.req_addr >> (OB + AW));

    // Unsigned stores do not exist; d/wu only exist on the 64-bit core.
    assign illegal = (bus.req_type == 3'b111) ||
                     ((XLEN == 32) && ((bus.req_type == 3'b011) || (bus.req_type == 3'b110))) ||
                     (bus.req_we && uns);

    assign req_err = misaligned || out_of_range || illegal;

    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept        = bus.req_valid && bus.req_ready && !rst;
    assign wr_en         = accept && bus.req_we && !req_err;
    assign rd_en         = accept && !bus.req_we && !req_err;

    always_comb begin
        be_size = '1;
        case (sz)
            2'd0:    be_size = NB'(4'h1);
            2'd1:    be_size = NB'(4'h3);
            2'd2:    be_size = NB'(4'hF);
            default: be_size = '1;
        endcase
    end

    assign be       = be_size << off;
    assign wdata_sh = bus.req_wdata << {off, 3'b000};

    // Untouched lanes are protected by the byte enables, so no read-modify-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][b] <= wdata_sh[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word <= mem[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            sz_q        <= 2'd0;
            off_q       <= '0;
            uns_q       <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= bus.req_we;
            rsp_err_q   <= req_err;
            sz_q        <= sz;
            off_q       <= off;
            uns_q       <= uns;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Lane extraction happens after the register so the RAM output feeds it directly.
    always_comb begin
        shifted = rd_word >> {off_q, 3'b000};
        mask    = '1;
        sbit    = shifted[XLEN-1];
        case (sz_q)
            2'd0: begin
                mask = XLEN'(8'hFF);
                sbit = shifted[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                sbit = shifted[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                sbit = shifted[31];
            end
            default: begin
                mask = '1;
                sbit = shifted[XLEN-1];
            end
        endcase
        load_val = (shifted & mask) | ((sbit && !uns_q) ? ~mask : '0);
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? load_val : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a 32-bit and a 64-bit instance, expected
// responses queued at issue time and compared when the response handshake fires.
module tb_dmem_ctrl;
    logic clk;
    logic rst;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall = 0;
    int cyc = 0;

    dmem_ctrl_if #(.XLEN(32)) if32();
    dmem_ctrl_if #(.XLEN(64)) if64();

    dmem_ctrl #(.XLEN(32), .DEPTH(256)) u32 (.clk(clk), .rst(rst), .bus(if32));
    dmem_ctrl #(.XLEN(64), .DEPTH(64))  u64 (.clk(clk), .rst(rst), .bus(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic issue32(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int n;
        if32.req_valid = 1'b1;
        if32.req_we    = we;
        if32.req_type  = typ;
        if32.req_addr  = addr;
        if32.req_wdata = wd;
        e.we = we; e.err = exp_e; e.data = 64'(exp_d);
        q32.push_back(e);
        n = 0;
        @(negedge clk);
        while (!if32.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept32_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        if32.req_valid = 1'b0;
    endtask

    task automatic issue64(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [63:0] exp_d, input logic exp_e);
        exp_t e;
        int n;
        if64.req_valid = 1'b1;
        if64.req_we    = we;
        if64.req_type  = typ;
        if64.req_addr  = addr;
        if64.req_wdata = wd;
        e.we = we; e.err = exp_e; e.data = exp_d;
        q64.push_back(e);
        n = 0;
        @(negedge clk);
        while (!if64.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept64_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        if64.req_valid = 1'b0;
    endtask

    // Response monitor for the 32-bit instance, including the stall-stability checks.
    exp_t        e32;
    logic        st_prev;
    logic [31:0] h_d;
    logic        h_e, h_w;
    initial begin
        st_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                st_prev = 1'b0;
            end else begin
                if (if32.rsp_valid && if32.rsp_ready) begin
                    if (q32.size() == 0) chk("rsp32_spurious", 64'(if32.rsp_valid), 64'd0);
                    else begin
                        e32 = q32.pop_front();
                        chk("rsp32_rdata", 64'(if32.rsp_rdata), e32.data);
                        chk("rsp32_err",   64'(if32.rsp_err),   64'(e32.err));
                        chk("rsp32_we",    64'(if32.rsp_we),    64'(e32.we));
                    end
                end
                if (if32.rsp_valid && !if32.rsp_ready) begin
                    n_stall++;
                    chk("stall_req_ready", 64'(if32.req_ready), 64'd0);
                    if (st_prev) begin
                        chk("stall_rdata", 64'(if32.rsp_rdata), 64'(h_d));
                        chk("stall_err",   64'(if32.rsp_err),   64'(h_e));
                        chk("stall_we",    64'(if32.rsp_we),    64'(h_w));
                    end
                    h_d = if32.rsp_rdata;
                    h_e = if32.rsp_err;
                    h_w = if32.rsp_we;
                    st_prev = 1'b1;
                end else begin
                    st_prev = 1'b0;
                end
            end
        end
    end

    exp_t e64;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && if64.rsp_valid && if64.rsp_ready) begin
                if (q64.size() == 0) chk("rsp64_spurious", 64'(if64.rsp_valid), 64'd0);
                else begin
                    e64 = q64.pop_front();
                    chk("rsp64_rdata", if64.rsp_rdata,        e64.data);
                    chk("rsp64_err",   64'(if64.rsp_err),     64'(e64.err));
                    chk("rsp64_we",    64'(if64.rsp_we),      64'(e64.we));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int s0;
        logic [3:0] pat;

        rst = 1'b1;
        if32.req_valid = 1'b0; if32.req_we = 1'b0; if32.req_type = 3'd0;
        if32.req_addr = 32'd0; if32.req_wdata = 32'd0; if32.rsp_ready = 1'b1;
        if64.req_valid = 1'b0; if64.req_we = 1'b0; if64.req_type = 3'd0;
        if64.req_addr = 32'd0; if64.req_wdata = 64'd0; if64.rsp_ready = 1'b1;

        @(negedge clk); @(negedge clk);
        chk("rst_rsp_valid", 64'(if32.rsp_valid), 64'd0);
        chk("rst_rsp_we",    64'(if32.rsp_we),    64'd0);
        chk("rst_rsp_rdata", 64'(if32.rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(if32.rsp_err),   64'd0);
        chk("rst64_rsp_valid", 64'(if64.rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(if32.req_ready), 64'd1);
        @(posedge clk); #1;

        // Byte store into a known word, signed/unsigned byte loads, full word.
        issue32(1, 3'b010, 32'h0, 32'h1122_3344, 32'h0, 0);
        issue32(1, 3'b000, 32'h3, 32'hFFFF_FFA5, 32'h0, 0);
        issue32(0, 3'b000, 32'h3, 32'h0, 32'hFFFF_FFA5, 0);
        issue32(0, 3'b100, 32'h3, 32'h0, 32'h0000_00A5, 0);
        issue32(0, 3'b010, 32'h0, 32'h0, 32'hA522_3344, 0);

        // Misaligned accesses fault and leave the word alone.
        issue32(1, 3'b010, 32'h4, 32'hCAFE_F00D, 32'h0, 0);
        issue32(1, 3'b001, 32'h7, 32'h0000_1234, 32'h0, 1);
        issue32(0, 3'b010, 32'h1, 32'h0, 32'h0, 1);
        issue32(0, 3'b010, 32'h4, 32'h0, 32'hCAFE_F00D, 0);
        issue32(0, 3'b001, 32'h6, 32'h0, 32'hFFFF_CAFE, 0);
        issue32(0, 3'b101, 32'h4, 32'h0, 32'h0000_F00D, 0);
        issue32(0, 3'b000, 32'h5, 32'h0, 32'hFFFF_FFF0, 0);

        // Illegal types and out-of-range addresses.
        issue32(0, 3'b011, 32'h8, 32'h0, 32'h0, 1);
        issue32(0, 3'b110, 32'h8, 32'h0, 32'h0, 1);
        issue32(0, 3'b111, 32'h8, 32'h0, 32'h0, 1);
        issue32(1, 3'b100, 32'h4, 32'h0, 32'h0, 1);
        issue32(0, 3'b010, 32'h4, 32'h0, 32'hCAFE_F00D, 0);
        issue32(0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
        issue32(1, 3'b010, 32'h400, 32'hDEAD_DEAD, 32'h0, 1);
        issue32(1, 3'b010, 32'h3FC, 32'h5A5A_0F0F, 32'h0, 0);
        issue32(0, 3'b010, 32'h3FC, 32'h0, 32'h5A5A_0F0F, 0);

        // Store then load on consecutive edges, at full throughput.
        c0 = cyc;
        issue32(1, 3'b010, 32'h10, 32'h8765_4321, 32'h0, 0);
        issue32(0, 3'b010, 32'h10, 32'h0, 32'h8765_4321, 0);
        issue32(1, 3'b001, 32'h12, 32'h0000_BEEF, 32'h0, 0);
        issue32(0, 3'b010, 32'h10, 32'h0, 32'hBEEF_4321, 0);
        chk("throughput_cycles", 64'(cyc - c0), 64'd4);

        // Backpressure: four back-to-back loads while rsp_ready toggles.
        s0 = n_stall;
        pat = 4'b1001;
        fork
            begin
                issue32(0, 3'b010, 32'h0,   32'h0, 32'hA522_3344, 0);
                issue32(0, 3'b010, 32'h4,   32'h0, 32'hCAFE_F00D, 0);
                issue32(0, 3'b010, 32'h10,  32'h0, 32'hBEEF_4321, 0);
                issue32(0, 3'b010, 32'h3FC, 32'h0, 32'h5A5A_0F0F, 0);
            end
            begin
                if32.rsp_ready = pat[3];
                for (int i = 2; i >= 0; i--) begin
                    @(posedge clk); #1;
                    if32.rsp_ready = pat[i];
                end
            end
        join
        if32.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_seen", 64'(n_stall > s0), 64'd1);
        chk("bp_drain", 64'(q32.size()), 64'd0);

        // Asynchronous reset with a stalled response pending.
        if32.rsp_ready = 1'b0;
        issue32(0, 3'b010, 32'h0, 32'h0, 32'hA522_3344, 0);
        @(negedge clk);
        chk("pre_rst_valid", 64'(if32.rsp_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(if32.rsp_valid), 64'd0);
        chk("async_rst_rdata", 64'(if32.rsp_rdata), 64'd0);
        q32.delete();
        if32.req_valid = 1'b1; if32.req_we = 1'b1; if32.req_type = 3'b010;
        if32.req_addr = 32'h0; if32.req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk); #1;
        if32.req_valid = 1'b0;
        if32.rsp_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ignored_valid", 64'(if32.rsp_valid), 64'd0);
        chk("rst_release_ready", 64'(if32.req_ready), 64'd1);
        @(posedge clk); #1;
        issue32(0, 3'b010, 32'h0, 32'h0, 32'hA522_3344, 0);
        issue32(0, 3'b000, 32'h3, 32'h0, 32'hFFFF_FFA5, 0);

        // 64-bit instance.
        issue64(1, 3'b011, 32'h8, 64'h8000_0000_DEAD_BEEF, 64'h0, 0);
        issue64(0, 3'b010, 32'hC, 64'h0, 64'hFFFF_FFFF_8000_0000, 0);
        issue64(0, 3'b110, 32'hC, 64'h0, 64'h0000_0000_8000_0000, 0);
        issue64(0, 3'b011, 32'h8, 64'h0, 64'h8000_0000_DEAD_BEEF, 0);
        issue64(0, 3'b010, 32'h200, 64'h0, 64'h0, 1);
        issue64(0, 3'b000, 32'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFEF, 0);
        issue64(0, 3'b101, 32'hA, 64'h0, 64'h0000_0000_0000_DEAD, 0);
        issue64(0, 3'b001, 32'hA, 64'h0, 64'hFFFF_FFFF_FFFF_DEAD, 0);
        issue64(1, 3'b010, 32'h8, 64'hFFFF_FFFF_1234_5678, 64'h0, 0);
        issue64(0, 3'b011, 32'h8, 64'h0, 64'h8000_0000_1234_5678, 0);
        issue64(0, 3'b011, 32'hC, 64'h0, 64'h0, 1);
        issue64(1, 3'b111, 32'h8, 64'h0, 64'h0, 1);
        issue64(0, 3'b011, 32'h8, 64'h0, 64'h8000_0000_1234_5678, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
